// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ==== truth_table_sweeper: drives every input combination, compares DUT output vs EXP_LUT ====
// ==== Revision: 1.0 ===========================================================================
module truth_table_sweeper #(
  parameter int                   N_IN    = 3,
  parameter int                   HOLD    = 10,
  parameter logic [(1<<N_IN)-1:0] EXP_LUT = 8'hE8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] vec_out,
  input  logic            y_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail_vec,
  output logic            first_fail_valid
);

  generate
    if (N_IN < 1 || N_IN > 8 || HOLD < 1 || HOLD > 255) begin : g_param_check
      $error("truth_table_sweeper: N_IN must be 1..8 and HOLD must be 1..255");
    end
  endgenerate

  localparam logic [7:0]      HOLD_LAST = 8'(HOLD - 1);
  localparam logic [N_IN-1:0] IDX_LAST  = {N_IN{1'b1}};
  localparam logic [N_IN:0]   ERR_MAX   = {1'b1, {N_IN{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          state_q;
  logic [N_IN-1:0] idx_q;
  logic [7:0]      hold_q;
  logic [N_IN-1:0] vec_q;
  logic            busy_q;
  logic            done_q;
  logic            pass_q;
  logic [N_IN:0]   err_q;
  logic [N_IN-1:0] ffv_q;
  logic            ffvalid_q;

  logic            sample;
  logic            mismatch;
  logic [N_IN:0]   err_d;

  // Compare happens only on the final cycle of each hold window.
  assign sample   = (state_q == S_DRIVE) && (hold_q == HOLD_LAST);
  assign mismatch = sample && (y_in != EXP_LUT[idx_q]);
  assign err_d    = (mismatch && (err_q != ERR_MAX)) ? err_q + 1'b1 : err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      hold_q    <= '0;
      vec_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= '0;
      ffv_q     <= '0;
      ffvalid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q   <= S_DRIVE;
            idx_q     <= '0;
            hold_q    <= '0;
            vec_q     <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= '0;
            ffv_q     <= '0;
            ffvalid_q <= 1'b0;
          end
        end
        S_DRIVE: begin
          err_q <= err_d;
          if (mismatch && !ffvalid_q) begin
            ffv_q     <= idx_q;
            ffvalid_q <= 1'b1;
          end
          if (hold_q == HOLD_LAST) begin
            hold_q <= '0;
            if (idx_q == IDX_LAST) begin
              state_q <= S_DONE;
              idx_q   <= '0;
              vec_q   <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_d == '0);
            end else begin
              idx_q <= idx_q + 1'b1;
              vec_q <= idx_q + 1'b1;
            end
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign vec_out          = vec_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
`default_nettype none
// ==== tb_truth_table_sweeper: scoreboard bench for the 3-input and 1-input sweeper configurations ====
// ==== Revision: 1.0 =================================================================================
module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  logic       rst;
  logic       start3, start1;
  logic [2:0] vec3;
  logic       y3, busy3, done3, pass3, ffvalid3;
  logic [3:0] err3;
  logic [2:0] ffv3;
  logic [0:0] vec1, ffv1;
  logic       y1, busy1, done1, pass1, ffvalid1;
  logic [1:0] err1;

  int         mode = 0;
  bit         small_zero = 1'b0;
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] lut3 = 8'hE8;
  logic [1:0] lut1 = 2'b10;

  typedef struct packed {
    logic [15:0] busy;
    logic [3:0]  err;
    logic [2:0]  ffv;
    logic        ffvalid;
    logic        pass;
  } res_t;

  res_t sbq[$];

  always #5 clk = ~clk;

  truth_table_sweeper #(.N_IN(3), .HOLD(10), .EXP_LUT(8'hE8)) u_dut (
    .clk(clk), .rst(rst), .start(start3), .vec_out(vec3), .y_in(y3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .first_fail_vec(ffv3), .first_fail_valid(ffvalid3)
  );

  truth_table_sweeper #(.N_IN(1), .HOLD(1), .EXP_LUT(2'b10)) u_small (
    .clk(clk), .rst(rst), .start(start1), .vec_out(vec1), .y_in(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_fail_vec(ffv1), .first_fail_valid(ffvalid1)
  );

  function automatic logic maj3(input logic [2:0] v);
    return (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
  endfunction

  // Mode 0: correct majority, 1: output flipped on vector 3 only, 2: flipped everywhere.
  function automatic logic model_y(input int m, input logic [2:0] v);
    return maj3(v) ^ ((m == 2) || (m == 1 && v == 3'd3));
  endfunction

  always_comb y3 = model_y(mode, vec3);
  always_comb y1 = small_zero ? 1'b0 : vec1[0];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_sweep3(input int m, input bit inject);
    res_t       e;
    res_t       g;
    logic [2:0] kv;
    int         busy_n;
    bit         seen_done;
    e = '0;
    e.busy = 16'd80;
    for (int k = 0; k < 8; k++) begin
      kv = 3'(k);
      if (model_y(m, kv) != lut3[k]) begin
        if (!e.ffvalid) begin
          e.ffv     = kv;
          e.ffvalid = 1'b1;
        end
        e.err = e.err + 4'd1;
      end
    end
    e.pass = (e.err == 4'd0);
    sbq.push_back(e);
    mode = m;
    @(negedge clk); start3 = 1'b1;
    @(negedge clk); start3 = 1'b0;
    check("start_clear_err", err3, 0);
    check("start_clear_ffvalid", ffvalid3, 0);
    check("start_busy", busy3, 1);
    check("start_done_low", done3, 0);
    busy_n = 0;
    seen_done = 1'b0;
    for (int cyc = 1; cyc <= 200 && !seen_done; cyc++) begin
      if (busy3) begin
        busy_n++;
        check("vec_step", vec3, (busy_n - 1) / 10);
      end
      if (done3) seen_done = 1'b1;
      else begin
        start3 = inject && (cyc == 25);
        @(negedge clk);
      end
    end
    start3 = 1'b0;
    g = sbq.pop_front();
    if (!seen_done) check("done_timeout", 0, 1);
    else begin
      check("busy_cycles", busy_n, g.busy);
      check("err_count", err3, g.err);
      check("first_fail_vec", ffv3, g.ffv);
      check("first_fail_valid", ffvalid3, g.ffvalid);
      check("pass", pass3, g.pass);
      check("done_vec_zero", vec3, 0);
      check("done_busy_low", busy3, 0);
    end
  endtask

  task automatic run_small(input bit zero_y);
    res_t e;
    res_t g;
    logic y;
    int   busy_n;
    bit   seen_done;
    e = '0;
    e.busy = 16'd2;
    for (int k = 0; k < 2; k++) begin
      y = zero_y ? 1'b0 : k[0];
      if (y != lut1[k]) begin
        if (!e.ffvalid) begin
          e.ffv     = 3'(k);
          e.ffvalid = 1'b1;
        end
        e.err = e.err + 4'd1;
      end
    end
    e.pass = (e.err == 4'd0);
    sbq.push_back(e);
    small_zero = zero_y;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    busy_n = 0;
    seen_done = 1'b0;
    for (int cyc = 1; cyc <= 20 && !seen_done; cyc++) begin
      if (busy1) begin
        busy_n++;
        check("small_vec_step", vec1, busy_n - 1);
      end
      if (done1) seen_done = 1'b1;
      else @(negedge clk);
    end
    g = sbq.pop_front();
    if (!seen_done) check("small_done_timeout", 0, 1);
    else begin
      check("small_busy_cycles", busy_n, g.busy);
      check("small_err_count", err1, g.err);
      check("small_first_fail_vec", ffv1, g.ffv);
      check("small_first_fail_valid", ffvalid1, g.ffvalid);
      check("small_pass", pass1, g.pass);
    end
  endtask

  initial begin
    rst    = 1'b1;
    start3 = 1'b0;
    start1 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy3, 0);
    check("rst_done", done3, 0);
    check("rst_vec", vec3, 0);
    check("rst_err", err3, 0);
    check("rst_small_done", done1, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_no_start", busy3, 0);

    run_sweep3(0, 1'b0);
    run_sweep3(1, 1'b0);
    run_sweep3(2, 1'b0);
    run_sweep3(0, 1'b0);
    run_sweep3(1, 1'b1);

    // Asynchronous reset landing between edges while vector 5 is held.
    mode = 2;
    @(negedge clk); start3 = 1'b1;
    @(negedge clk); start3 = 1'b0;
    for (int i = 0; i < 100 && vec3 != 3'd5; i++) @(negedge clk);
    check("reach_vec5", vec3, 5);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", busy3, 0);
    check("async_rst_vec", vec3, 0);
    check("async_rst_err", err3, 0);
    check("async_rst_ffvalid", ffvalid3, 0);
    check("async_rst_done", done3, 0);
    @(negedge clk); rst = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_idle_busy", busy3, 0);
    check("post_rst_idle_done", done3, 0);
    check("post_rst_idle_vec", vec3, 0);

    run_sweep3(0, 1'b0);
    run_small(1'b0);
    run_small(1'b1);
    check("scoreboard_empty", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Self-checking exhaustive stimulus engine for small combinational blocks with N_IN single-bit inputs and one output.
- On start, it drives every input combination in ascending binary order and holds each one for HOLD cycles.
- On the last held cycle it samples the DUT output and compares it against a golden truth table given as a parameter.
- Reports mismatch count, first failing vector and pass/fail. Sits beside the DUT in synthesizable self-test wrappers and benches, replacing hand-written #delay vector lists.

Parameters:
- N_IN, 3, number of DUT inputs; legal 1..8.
- HOLD, 10, cycles each vector is held; legal 1..255.
- EXP_LUT, 8'hE8, expected output table of width 2**N_IN; bit k is the expected Y when the inputs equal k.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a sweep; sampled only in IDLE or DONE.
- vec_out  output  N_IN  stimulus to the DUT; MSB maps to the first DUT input (A), LSB to the last (C).
- y_in  input  1  DUT output under test.
- busy  output  1  high while vectors are being driven.
- done  output  1  level; high in DONE until the next start or reset.
- pass  output  1  valid when done=1; 1 if err_count==0.
- err_count  output  N_IN+1  number of mismatching vectors in the current or last sweep.
- first_fail_vec  output  N_IN  first vector that mismatched.
- first_fail_valid  output  1  high once any mismatch has been recorded in this sweep.

Behaviour:
- Reset (async, immediate): state=IDLE; vec_out=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=0, first_fail_valid=0; vector index and hold counter cleared.
- Reset mid-sweep aborts the sweep with no partial result kept. The first sweep after reset deassertion requires a new start.
- States:
  - IDLE: start=1 at an edge -> DRIVE. On that same edge: index=0, hold=0, busy=1, done=0, and err_count, first_fail_* cleared.
  - DRIVE: vec_out=index every cycle. hold increments each edge.
    - When hold==HOLD-1, the edge compares y_in against EXP_LUT[index].
    - On mismatch: err_count+1. If first_fail_valid=0, first_fail_vec=index and first_fail_valid=1.
    - On that same edge hold returns to 0. If index==2**N_IN-1 -> DONE, else index+1.
  - DONE: busy=0, done=1, pass=(err_count==0). vec_out returns to 0. start=1 -> DRIVE, clearing results exactly as from IDLE.
- start while in DRIVE is ignored; no restart and no effect on counters.
- Timing: busy is high for exactly (2**N_IN)*HOLD cycles. done rises on the edge that ends the last hold cycle.
- Sampling point: y_in is sampled at the end of the last cycle of each hold window, so the DUT has HOLD-1 full cycles to settle. With HOLD=1, sampling occurs in the same cycle the vector is driven.
- err_count saturates at 2**N_IN, which is reachable, so no wrap is possible at the chosen width.
- index and hold are internal. Width of index is N_IN bits; hold is 8 bits. No wrap occurs beyond the terminal compare.
- HOLD=0 and N_IN outside 1..8 are illegal. They need not be checked in RTL but must be flagged by a generate-time $error.

Test Plan:
- Defaults, y_in driven by a 3-input majority model -> busy high for exactly 80 cycles, then done=1, pass=1, err_count=0, first_fail_valid=0. vec_out steps 0..7, each held 10 cycles.
- Same as above, but the model output is forced inverted only for vector 3 -> err_count=1, first_fail_vec=3, first_fail_valid=1, pass=0.
- y_in = ~majority for all vectors -> err_count=8 (saturation value, no wrap), first_fail_vec=0, pass=0.
- Pulse start at cycle 25 of a sweep -> ignored; sweep still ends at cycle 80 with identical results. Then start in DONE -> results clear on that edge and a second full sweep runs.
- Assert rst asynchronously (between edges) during vector 5 -> all outputs 0 immediately, state IDLE. After deassert, nothing happens until start; the next sweep begins at vector 0.
- N_IN=1, HOLD=1, EXP_LUT=2'b10, y_in=vec_out -> busy for 2 cycles, pass=1. Repeat with y_in=0 -> err_count=1, first_fail_vec=1.
